// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Holds one control bundle and one datapath bundle behind valid/ready flow control.
// It supports flush-to-bubble and counts stalled cycles in a saturating counter.
//
// Optional feature: define PIPE_SKID_EN to add a 1-entry skid buffer.
// With the skid buffer, in_ready comes straight from a register and capacity is 2 beats.
// Without it, in_ready = ~out_valid | out_ready and capacity is 1 beat.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous reset, active-high
//   flush      kill held (and skid) beat plus any beat offered this cycle
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat this cycle
//   in_ctrl    upstream control bundle
//   in_data    upstream datapath bundle
//   out_valid  held beat valid
//   out_ready  downstream consumes the held beat this cycle
//   out_ctrl   held control; zero whenever out_valid=0
//   out_data   held datapath; stable but meaningless when out_valid=0
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              accept;
    logic              rel;

`ifdef PIPE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    // Registered ready: the skid slot absorbs the beat that arrives while stalled.
    assign in_ready = ~skid_valid_q;
`else
    assign in_ready = ~out_valid_q | out_ready;
`endif

    assign accept = in_valid & in_ready;
    assign rel    = out_valid_q & out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_ctrl_d  = out_ctrl_q;
        out_data_d  = out_data_q;
`ifdef PIPE_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
`endif
        if (flush) begin
            // Offered beat is dropped even though upstream sees it as consumed.
            out_valid_d = 1'b0;
            out_ctrl_d  = '0;
`ifdef PIPE_SKID_EN
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
`endif
        end else begin
`ifdef PIPE_SKID_EN
            if (rel) begin
                if (skid_valid_q) begin
                    // in_ready is low while skid is full, so no accept can coincide.
                    out_valid_d  = 1'b1;
                    out_ctrl_d   = skid_ctrl_q;
                    out_data_d   = skid_data_q;
                    skid_valid_d = 1'b0;
                    skid_ctrl_d  = '0;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    out_ctrl_d  = in_ctrl;
                    out_data_d  = in_data;
                end else begin
                    out_valid_d = 1'b0;
                    out_ctrl_d  = '0;
                end
            end else if (accept) begin
                if (out_valid_q) begin
                    skid_valid_d = 1'b1;
                    skid_ctrl_d  = in_ctrl;
                    skid_data_d  = in_data;
                end else begin
                    out_valid_d = 1'b1;
                    out_ctrl_d  = in_ctrl;
                    out_data_d  = in_data;
                end
            end
`else
            if (accept) begin
                out_valid_d = 1'b1;
                out_ctrl_d  = in_ctrl;
                out_data_d  = in_data;
            end else if (rel) begin
                out_valid_d = 1'b0;
                out_ctrl_d  = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= '0;
`ifdef PIPE_SKID_EN
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_ctrl_q  <= out_ctrl_d;
`ifdef PIPE_SKID_EN
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
`endif
        end
    end

    // Datapath bundles are not reset; they only need to hold across reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data_q <= out_data_d;
`ifdef PIPE_SKID_EN
            skid_data_q <= skid_data_d;
`endif
        end
    end

    // Counts on the pre-update state; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_data  = out_data_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int DW = 96;
    localparam int CW = 4;
    localparam int NW = 16;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;

    logic          s_in_ready, s_out_valid;
    logic [CW-1:0] s_out_ctrl;
    logic [DW-1:0] s_out_data;
    logic [3:0]    s_stall_cnt;

    int checks   = 0;
    int failures = 0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    // Narrow counter instance for the saturation test; shares all inputs.
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_ctrl  (s_out_ctrl),
        .out_data  (s_out_data),
        .stall_cnt (s_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_ctrl = 4'h5; in_data = 96'h77;
        out_ready = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++;
            $display("FAIL rst_valid got=%b exp=0", out_valid); end
        checks++; if (out_ctrl !== 4'h0) begin failures++;
            $display("FAIL rst_ctrl got=%h exp=0", out_ctrl); end
        checks++; if (stall_cnt !== 16'd0) begin failures++;
            $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (s_stall_cnt !== 4'd0) begin failures++;
            $display("FAIL rst_cnt_sat got=%0d exp=0", s_stall_cnt); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL rst_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_ctrl = CW'(i); in_data = DW'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++;
                $display("FAIL stream_ready i=%0d got=%b exp=1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== DW'(i) || out_ctrl !== CW'(i)) begin
                failures++;
                $display("FAIL stream_beat i=%0d got v=%b c=%h d=%h exp v=1 c=%h d=%h",
                         i, out_valid, out_ctrl, out_data, CW'(i), DW'(i));
            end
            checks++; if (stall_cnt !== 16'd0) begin failures++;
                $display("FAIL stream_cnt got=%0d exp=0", stall_cnt); end
        end
        // Invalid beat with nonzero ctrl must not be captured.
        in_valid = 1'b0; in_ctrl = 4'hC; in_data = 96'hDEAD;
        tick();
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0) begin failures++;
            $display("FAIL stream_drain got v=%b c=%h exp v=0 c=0", out_valid, out_ctrl); end
        checks++; if (out_data !== 96'h5) begin failures++;
            $display("FAIL stream_hold got=%h exp=5", out_data); end
    endtask

    task automatic test_backpressure();
        logic exp_rdy;
        in_valid = 1'b1; in_ctrl = 4'h3; in_data = 96'hA; out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 96'hA) begin failures++;
            $display("FAIL bp_first got v=%b d=%h exp v=1 d=a", out_valid, out_data); end
        in_ctrl = 4'h6; in_data = 96'hB;
        for (int k = 0; k < 4; k++) begin
            #1;
`ifdef PIPE_SKID_EN
            exp_rdy = (k == 0);
`else
            exp_rdy = 1'b0;
`endif
            checks++; if (in_ready !== exp_rdy) begin failures++;
                $display("FAIL bp_ready k=%0d got=%b exp=%b", k, in_ready, exp_rdy); end
            tick();
`ifdef PIPE_SKID_EN
            in_valid = 1'b0;
`endif
            checks++; if (out_valid !== 1'b1 || out_data !== 96'hA || out_ctrl !== 4'h3) begin
                failures++;
                $display("FAIL bp_hold k=%0d got v=%b c=%h d=%h exp v=1 c=3 d=a",
                         k, out_valid, out_ctrl, out_data);
            end
        end
        checks++; if (stall_cnt !== 16'd4) begin failures++;
            $display("FAIL bp_cnt got=%0d exp=4", stall_cnt); end
        out_ready = 1'b1;
`ifndef PIPE_SKID_EN
        in_valid = 1'b1;
`endif
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 96'hB || out_ctrl !== 4'h6) begin
            failures++;
            $display("FAIL bp_next got v=%b c=%h d=%h exp v=1 c=6 d=b", out_valid, out_ctrl, out_data);
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0) begin failures++;
            $display("FAIL bp_empty got v=%b c=%h exp v=0 c=0", out_valid, out_ctrl); end
        checks++; if (stall_cnt !== 16'd4) begin failures++;
            $display("FAIL bp_cnt_after got=%0d exp=4", stall_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 4'h2; in_data = 96'h11;
        tick();
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 4'h2) begin failures++;
            $display("FAIL fl_setup got v=%b c=%h exp v=1 c=2", out_valid, out_ctrl); end
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 4'hF; in_data = 96'h99;
        tick();
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0) begin failures++;
            $display("FAIL fl_clear got v=%b c=%h exp v=0 c=0", out_valid, out_ctrl); end
        checks++; if (stall_cnt !== 16'd5) begin failures++;
            $display("FAIL fl_cnt got=%0d exp=5", stall_cnt); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL fl_ready got=%b exp=1", in_ready); end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0) begin failures++;
                $display("FAIL fl_dropped k=%0d got v=%b c=%h exp v=0 c=0", k, out_valid, out_ctrl);
            end
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (s_stall_cnt !== 4'd0) begin failures++;
            $display("FAIL sat_rst0 got=%0d exp=0", s_stall_cnt); end
        in_valid = 1'b1; in_ctrl = 4'h1; in_data = 96'h5A; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (15) tick();
        checks++; if (s_stall_cnt !== 4'd15) begin failures++;
            $display("FAIL sat_15 got=%0d exp=15", s_stall_cnt); end
        repeat (5) tick();
        checks++; if (s_stall_cnt !== 4'd15) begin failures++;
            $display("FAIL sat_hold got=%0d exp=15", s_stall_cnt); end
        checks++; if (stall_cnt !== 16'd20) begin failures++;
            $display("FAIL sat_wide got=%0d exp=20", stall_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (s_stall_cnt !== 4'd0 || stall_cnt !== 16'd0) begin failures++;
            $display("FAIL sat_clear got=%0d/%0d exp=0/0", s_stall_cnt, stall_cnt); end
        checks++; if (out_valid !== 1'b0 || s_out_valid !== 1'b0) begin failures++;
            $display("FAIL sat_rst_valid got=%b/%b exp=0/0", out_valid, s_out_valid); end
    endtask

    task automatic test_random();
        beat_t       q[$];
        beat_t       b;
        int unsigned mcnt;
        logic        exp_rdy, exp_v, acc, rel;
        mcnt = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            in_ctrl   = 4'($urandom);
            in_data   = {32'hC0DE, 32'(cyc), 32'($urandom)};
            #1;
`ifdef PIPE_SKID_EN
            exp_rdy = (q.size() < 2);
`else
            exp_rdy = (q.size() == 0) || out_ready;
`endif
            exp_v = (q.size() > 0);
            checks++; if (in_ready !== exp_rdy) begin failures++;
                $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
            checks++; if (out_valid !== exp_v) begin failures++;
                $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (out_ctrl !== q[0].c || out_data !== q[0].d) begin failures++;
                    $display("FAIL rnd_beat cyc=%0d got c=%h d=%h exp c=%h d=%h",
                             cyc, out_ctrl, out_data, q[0].c, q[0].d);
                end
            end else begin
                checks++; if (out_ctrl !== 4'h0) begin failures++;
                    $display("FAIL rnd_bubble_ctrl cyc=%0d got=%h exp=0", cyc, out_ctrl); end
            end
            checks++; if (stall_cnt !== NW'(mcnt)) begin failures++;
                $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, mcnt); end
            acc = in_valid && exp_rdy;
            rel = exp_v && out_ready;
            if (exp_v && !out_ready && mcnt < 65535) mcnt++;
            b.c = in_ctrl;
            b.d = in_data;
            tick();
            if (flush) begin
                q.delete();
            end else begin
                if (rel) void'(q.pop_front());
                if (acc) q.push_back(b);
            end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
